// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    // Index width that stays at least one bit wide for single-channel builds.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_if.sv
// Duty write port: one strobe per cycle, addressed by channel index.
interface pwm_if #(
    parameter int CH = 4,
    parameter int CW = 8
);
    localparam int CHW = pwm_pkg::clog2_min1(CH);

    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_duty;

    modport master (output wr_en, wr_ch, wr_duty);
    modport slave  (input  wr_en, wr_ch, wr_duty);
endinterface

// File: rtl/pwm_channel.sv
// One PWM lane: shadow/active duty pair and the registered compare output.
module pwm_channel #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [CW-1:0] wr_duty,
    input  logic          load,
    input  logic [CW-1:0] cnt,
    input  logic          en,
    output logic          pwm_out
);

    logic [CW-1:0] shadow;
    logic [CW-1:0] active;

    // A write coinciding with load leaves active on the old shadow value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (wr)   shadow <= wr_duty;
            if (load) active <= shadow;
            pwm_out <= en && (cnt < active);
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// Shared-timebase PWM generator: edge/center counting with boundary-latched settings.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          mode,
    input  logic [CW-1:0] period,
    pwm_if.slave          wr,
    output logic [CH-1:0] pwm_out,
    output logic          period_start
);

    localparam int CHW = clog2_min1(CH);

    logic [CW-1:0] cnt;
    logic [CW-1:0] top_act;
    logic          dir_dn;
    logic          mode_act;
    logic          wrap;
    logic          load;

    // top_act==1 in center mode wraps on the way up, so the count never goes below 0.
    always_comb begin
        wrap = 1'b0;
        if (en) begin
            if (mode_act == PWM_MODE_EDGE)
                wrap = (cnt == top_act);
            else
                wrap = (top_act == '0) ||
                       ((cnt == CW'(1)) && (dir_dn || (top_act == CW'(1))));
        end
    end

    assign load = wrap | ~en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            dir_dn       <= 1'b0;
            top_act      <= '0;
            mode_act     <= PWM_MODE_EDGE;
            period_start <= 1'b0;
        end else begin
            period_start <= en && (cnt == '0);
            if (load) begin
                cnt      <= '0;
                dir_dn   <= 1'b0;
                top_act  <= period;
                mode_act <= mode;
            end else if ((mode_act == PWM_MODE_CENTER) && (dir_dn || (cnt == top_act))) begin
                dir_dn <= 1'b1;
                cnt    <= cnt - CW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Out-of-range indices match no lane, so such writes fall away naturally.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_channel #(.CW(CW)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr.wr_en && (wr.wr_ch == CHW'(i))),
            .wr_duty (wr.wr_duty),
            .load    (load),
            .cnt     (cnt),
            .en      (en),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench: 4-channel PWM plus a 3-channel copy used for out-of-range writes.
module tb_pwm_multi_channel;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       mode;
    logic [7:0] period;
    logic [3:0] pwm_out;
    logic [2:0] pwm_out3;
    logic       ps;
    logic       ps3;
    int         ncmp = 0;
    int         nerr = 0;
    int         pnum = 0;

    pwm_if #(.CH(4), .CW(8)) w ();
    pwm_if #(.CH(3), .CW(8)) w3 ();

    pwm_multi_channel #(.CH(4), .CW(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .period(period),
        .wr(w), .pwm_out(pwm_out), .period_start(ps)
    );

    pwm_multi_channel #(.CH(3), .CW(8)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .period(period),
        .wr(w3), .pwm_out(pwm_out3), .period_start(ps3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] obsv();
        return {ps3, ps, pwm_out, pwm_out3};
    endfunction

    // Duties on ch1..ch3 stay 0/10/255; ch0 duty d0. Optional write/config change mid-period.
    task automatic run_period(input int top, input bit ctr, input int d0,
                              input int wr_at, input int wr_val,
                              input int chg_at, input bit nmode, input int nper);
        int len;
        len = ctr ? 2 * top : top + 1;
        for (int i = 0; i < len; i++) begin
            int c;
            c = (ctr && i > top) ? 2 * top - i : i;
            if (i == wr_at) begin
                w.wr_en = 1'b1; w.wr_ch = 2'd0; w.wr_duty = 8'(wr_val);
            end
            if (i == chg_at) begin
                mode = nmode; period = 8'(nper);
                w3.wr_en = 1'b1; w3.wr_ch = 2'd3; w3.wr_duty = 8'hC8;
            end
            tick();
            w.wr_en = 1'b0; w3.wr_en = 1'b0;
            chk($sformatf("p%0d_i%0d", pnum, i), obsv(),
                {i == 0, i == 0, c < 255, c < 10, 1'b0, c < d0, 3'b000});
        end
        pnum++;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0; period = 8'd9;
        w.wr_en = 1'b0;  w.wr_ch = '0;  w.wr_duty = '0;
        w3.wr_en = 1'b0; w3.wr_ch = '0; w3.wr_duty = '0;
        tick();
        chk("reset", obsv(), 9'b0);
        reset = 1'b0;

        for (int k = 0; k < 4; k++) begin
            w.wr_en = 1'b1; w.wr_ch = 2'(k);
            w.wr_duty = (k == 0) ? 8'd3 : (k == 1) ? 8'd0 : (k == 2) ? 8'd10 : 8'd255;
            tick();
        end
        w.wr_en = 1'b0;
        tick();
        chk("idle_en0", obsv(), 9'b0);

        // Edge mode, period 10, duties 3/0/10/255
        en = 1'b1;
        run_period(9, 0, 3, -1, 0, -1, 0, 0);
        run_period(9, 0, 3, -1, 0, -1, 0, 0);
        // Mid-period duty write: no runt, new duty next period
        run_period(9, 0, 3, 5, 7, -1, 0, 0);
        run_period(9, 0, 7, -1, 0, -1, 0, 0);
        // Write in the boundary cycle is deferred one extra period
        run_period(9, 0, 7, 5, 3, -1, 0, 0);
        run_period(9, 0, 3, 9, 6, -1, 0, 0);
        run_period(9, 0, 3, -1, 0, -1, 0, 0);
        run_period(9, 0, 6, -1, 0, -1, 0, 0);
        // Mode/period change plus out-of-range write mid-period
        run_period(9, 0, 6, 4, 2, 3, 1, 4);
        // Center mode, top 4, duty 2
        run_period(4, 1, 2, -1, 0, -1, 0, 0);
        run_period(4, 1, 2, -1, 0, -1, 0, 0);

        // Drop en mid-period
        tick(); tick(); tick();
        en = 1'b0;
        tick();
        chk("en_drop", obsv(), 9'b0);
        mode = 1'b0; period = 8'd5;
        w.wr_en = 1'b1; w.wr_ch = 2'd0; w.wr_duty = 8'd2;
        tick();
        w.wr_en = 1'b0;
        chk("en0_hold1", obsv(), 9'b0);
        tick();
        chk("en0_hold2", obsv(), 9'b0);
        en = 1'b1;
        run_period(5, 0, 2, -1, 0, -1, 0, 0);

        // Async reset mid-period
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("async_reset", obsv(), 9'b0);
        en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_en0", obsv(), 9'b0);
        en = 1'b1;
        tick();
        chk("post_reset_start", obsv(), 9'b110000000);
        tick();
        chk("post_reset_cnt1", obsv(), 9'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
